// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR range sampler slice.
package lfsr_pkg;

  localparam int LFSR_W = 32;

  localparam int DEF_W         = 8;
  localparam int DEF_MAX_TRIES = 8;
  localparam int DEF_STRIDE    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    RESP   = 2'd2
  } sampler_state_e;

endpackage

// File: rtl/lfsr_mask_gen.sv
// Turns a range into the smallest all-ones mask covering range-1.
// The result is meaningless for range 0; the caller handles that case separately.
module lfsr_mask_gen #(
  parameter int W = 8
) (
  input  logic [W-1:0] range_i,
  output logic [W-1:0] mask_o
);

  logic [W-1:0] range_m1;

  assign range_m1 = range_i - W'(1);

  // Smear the most significant set bit of range-1 into every lower position.
  always_comb begin
    mask_o = range_m1;
    for (int i = 1; i < W; i++) begin
      mask_o = mask_o | (range_m1 >> i);
    end
  end

endmodule

// File: rtl/lfsr_range_sampler.sv
// Rejection-samples successive LFSR states into a value in [0, range),
// with a bounded number of retries and a masked fallback that is always in range.
module lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  parameter int STRIDE    = DEF_STRIDE
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [LFSR_W-1:0] lfsr_state_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [W-1:0]      req_range_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [W-1:0]      rsp_value_o,
  output logic              rsp_fallback_o,
  output logic              rsp_error_o
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int SW = $clog2(STRIDE + 1);
  localparam logic [TW-1:0] LAST_TRY      = TW'(MAX_TRIES - 1);
  localparam logic [SW-1:0] STRIDE_RELOAD = SW'(STRIDE - 1);

  sampler_state_e state_q, state_d;
  logic [W-1:0]   range_q, range_d;
  logic [W-1:0]   mask_q, mask_d;
  logic [TW-1:0]  tries_q, tries_d;
  logic [SW-1:0]  stride_q, stride_d;
  logic [W-1:0]   value_q, value_d;
  logic           fallback_q, fallback_d;
  logic           error_q, error_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic [W-1:0]   req_mask;
  logic [W-1:0]   cand;
  logic           unused_lfsr_hi;

  // Only the low W bits of the LFSR feed the candidate.
  assign unused_lfsr_hi = ^lfsr_state_i[LFSR_W-1:W];

  lfsr_mask_gen #(
    .W(W)
  ) u_mask_gen (
    .range_i(req_range_i),
    .mask_o (req_mask)
  );

  assign cand = lfsr_state_i[W-1:0] & mask_q;

  // Next-state and datapath: accept, sample with stride spacing, then hold the response.
  always_comb begin
    state_d    = state_q;
    range_d    = range_q;
    mask_d     = mask_q;
    tries_d    = tries_q;
    stride_d   = stride_q;
    value_d    = value_q;
    fallback_d = fallback_q;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          range_d  = req_range_i;
          mask_d   = req_mask;
          tries_d  = '0;
          stride_d = '0;
          if (req_range_i == '0) begin
            state_d    = RESP;
            value_d    = '0;
            error_d    = 1'b1;
            fallback_d = 1'b0;
          end else begin
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        if (stride_q == '0) begin
          if (cand < range_q) begin
            state_d    = RESP;
            value_d    = cand;
            fallback_d = 1'b0;
            error_d    = 1'b0;
          end else if (tries_q == LAST_TRY) begin
            state_d    = RESP;
            value_d    = cand & (mask_q >> 1);
            fallback_d = 1'b1;
            error_d    = 1'b0;
          end else begin
            tries_d  = tries_q + TW'(1);
            stride_d = STRIDE_RELOAD;
          end
        end else begin
          stride_d = stride_q - SW'(1);
        end
      end

      RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      range_q     <= '0;
      mask_q      <= '0;
      tries_q     <= '0;
      stride_q    <= '0;
      value_q     <= '0;
      fallback_q  <= 1'b0;
      error_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      range_q     <= range_d;
      mask_q      <= mask_d;
      tries_q     <= tries_d;
      stride_q    <= stride_d;
      value_q     <= value_d;
      fallback_q  <= fallback_d;
      error_q     <= error_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_value_o    = value_q;
  assign rsp_fallback_o = fallback_q;
  assign rsp_error_o    = error_q;

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Self-checking bench for lfsr_range_sampler: directed edge cases plus random requests
// checked against an arithmetic rejection-sampling model.
module tb_lfsr_range_sampler;

  localparam int W         = 8;
  localparam int MAX_TRIES = 8;
  localparam int STRIDE    = 4;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [31:0]   lfsr_state_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [W-1:0]  req_range_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [W-1:0]  rsp_value_o;
  logic          rsp_fallback_o;
  logic          rsp_error_o;

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [31:0] seq [0:63];

  lfsr_range_sampler #(
    .W(W),
    .MAX_TRIES(MAX_TRIES),
    .STRIDE(STRIDE)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .lfsr_state_i  (lfsr_state_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_range_i   (req_range_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_value_o   (rsp_value_o),
    .rsp_fallback_o(rsp_fallback_o),
    .rsp_error_o   (rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: seq[c] is the LFSR word presented in cycle c after the request edge.
  // Try k looks at seq[1 + k*STRIDE]; its response shows up in cycle 2 + k*STRIDE.
  function automatic void model(input int rng, output int lat, output int val,
                                output bit fb, output bit err);
    int m;
    int cand;
    m = 0;
    while (m < rng - 1) m = m * 2 + 1;
    lat = 0; val = 0; fb = 1'b0; err = 1'b0;
    if (rng == 0) begin
      lat = 1;
      err = 1'b1;
      return;
    end
    for (int k = 0; k < MAX_TRIES; k++) begin
      cand = int'(seq[1 + k * STRIDE][7:0]) & m;
      if (cand < rng) begin
        lat = 2 + k * STRIDE;
        val = cand;
        return;
      end
    end
    cand = int'(seq[1 + (MAX_TRIES - 1) * STRIDE][7:0]) & m;
    val  = cand & (m >> 1);
    fb   = 1'b1;
    lat  = 2 + (MAX_TRIES - 1) * STRIDE;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) seq[i] = $urandom;
  endtask

  // Issues one request, follows it to the response, applies backpressure, then completes it.
  task automatic run_request(input int rng, input int hold, input string name);
    int exp_lat, exp_val, lat;
    bit exp_fb, exp_err;
    model(rng, exp_lat, exp_val, exp_fb, exp_err);

    if (req_ready_o !== 1'b1) begin
      $display("[TB] FAIL %s ready_before_req: got %b want 1", name, req_ready_o);
      n_miscompares++;
    end
    n_vectors++;

    req_valid_i  = 1'b1;
    req_range_i  = W'(rng);
    lfsr_state_i = seq[0];
    rsp_ready_i  = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_range_i = W'($urandom);

    lat = 0;
    for (int c = 1; c < 60; c++) begin
      if (rsp_valid_o === 1'b1) begin
        lat = c;
        break;
      end
      if (req_ready_o !== 1'b0) begin
        $display("[TB] FAIL %s ready_while_busy: cycle %0d got %b want 0", name, c, req_ready_o);
        n_miscompares++;
      end
      n_vectors++;
      lfsr_state_i = seq[c];
      @(posedge clk_i); #1;
    end

    if (lat != exp_lat) begin
      $display("[TB] FAIL %s latency: got %0d want %0d (0 = timeout)", name, lat, exp_lat);
      n_miscompares++;
    end
    n_vectors++;
    if (rsp_value_o !== W'(exp_val)) begin
      $display("[TB] FAIL %s value: got %0d want %0d", name, rsp_value_o, exp_val);
      n_miscompares++;
    end
    n_vectors++;
    if (rsp_fallback_o !== exp_fb) begin
      $display("[TB] FAIL %s fallback: got %b want %b", name, rsp_fallback_o, exp_fb);
      n_miscompares++;
    end
    n_vectors++;
    if (rsp_error_o !== exp_err) begin
      $display("[TB] FAIL %s error: got %b want %b", name, rsp_error_o, exp_err);
      n_miscompares++;
    end
    n_vectors++;

    for (int h = 0; h < hold; h++) begin
      req_valid_i  = 1'b1;
      req_range_i  = W'($urandom);
      lfsr_state_i = $urandom;
      @(posedge clk_i); #1;
      if ({rsp_valid_o, req_ready_o, rsp_value_o, rsp_fallback_o, rsp_error_o} !==
          {1'b1, 1'b0, W'(exp_val), exp_fb, exp_err}) begin
        $display("[TB] FAIL %s hold_stable: cycle %0d got v=%b r=%b val=%0d fb=%b err=%b want v=1 r=0 val=%0d fb=%b err=%b",
                 name, h, rsp_valid_o, req_ready_o, rsp_value_o, rsp_fallback_o, rsp_error_o,
                 exp_val, exp_fb, exp_err);
        n_miscompares++;
      end
      n_vectors++;
    end

    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      $display("[TB] FAIL %s after_handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, rsp_valid_o, req_ready_o);
      n_miscompares++;
    end
    n_vectors++;

    @(posedge clk_i); #1;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      $display("[TB] FAIL %s idle_after: got valid=%b ready=%b want valid=0 ready=1",
               name, rsp_valid_o, req_ready_o);
      n_miscompares++;
    end
    n_vectors++;
  endtask

  task automatic test_reset();
    reset_ni     = 1'b0;
    req_valid_i  = 1'b0;
    req_range_i  = '0;
    rsp_ready_i  = 1'b0;
    lfsr_state_i = $urandom;
    repeat (3) @(posedge clk_i);
    #1;
    if ({req_ready_o, rsp_valid_o, rsp_value_o, rsp_fallback_o, rsp_error_o} !==
        {1'b1, 1'b0, W'(0), 1'b0, 1'b0}) begin
      $display("[TB] FAIL reset_state: got r=%b v=%b val=%0d fb=%b err=%b want r=1 v=0 val=0 fb=0 err=0",
               req_ready_o, rsp_valid_o, rsp_value_o, rsp_fallback_o, rsp_error_o);
      n_miscompares++;
    end
    n_vectors++;
    #3 reset_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_accept_first();
    fill_random();
    seq[1] = {seq[1][31:8], 8'h07};
    run_request(10, 0, "accept_first");
  endtask

  task automatic test_reject_then_accept();
    fill_random();
    seq[1] = {seq[1][31:8], 8'h0D};
    seq[5] = {seq[5][31:8], 8'h03};
    run_request(10, 0, "reject_then_accept");
  endtask

  task automatic test_fallback();
    fill_random();
    for (int k = 0; k < MAX_TRIES; k++)
      seq[1 + k * STRIDE] = {seq[1 + k * STRIDE][31:8], 8'h07};
    run_request(5, 0, "fallback");
  endtask

  task automatic test_range_edges();
    fill_random();
    run_request(0, 0, "range_0");
    fill_random();
    run_request(1, 0, "range_1");
    fill_random();
    seq[1] = {seq[1][31:8], 8'hFF};
    run_request(128, 0, "range_128");
  endtask

  task automatic test_backpressure();
    fill_random();
    seq[1] = {seq[1][31:8], 8'h09};
    run_request(10, 10, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      fill_random();
      run_request(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_reset_mid_sample();
    fill_random();
    req_valid_i  = 1'b1;
    req_range_i  = 8'd5;
    lfsr_state_i = 32'h0000_0007;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    #2 reset_ni = 1'b0;
    #1;
    if ({req_ready_o, rsp_valid_o, rsp_value_o, rsp_fallback_o, rsp_error_o} !==
        {1'b1, 1'b0, W'(0), 1'b0, 1'b0}) begin
      $display("[TB] FAIL mid_reset_async: got r=%b v=%b val=%0d fb=%b err=%b want r=1 v=0 val=0 fb=0 err=0",
               req_ready_o, rsp_valid_o, rsp_value_o, rsp_fallback_o, rsp_error_o);
      n_miscompares++;
    end
    n_vectors++;
    #1 reset_ni = 1'b1;
    for (int c = 0; c < 40; c++) begin
      lfsr_state_i = 32'h0000_0003;
      @(posedge clk_i); #1;
      if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
        $display("[TB] FAIL mid_reset_no_stale: cycle %0d got valid=%b ready=%b want valid=0 ready=1",
                 c, rsp_valid_o, req_ready_o);
        n_miscompares++;
      end
      n_vectors++;
    end
  endtask

  // Scenario sequence; a fresh request after the mid-sample reset confirms recovery.
  initial begin
    test_reset();
    test_accept_first();
    test_reject_then_accept();
    test_fallback();
    test_range_edges();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sample();
    test_accept_first();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
Consumes the free-running 32-bit LFSR state and turns it into bounded random numbers on request.
- A requester asks for a value in [0, range).
- The block uses rejection sampling over successive LFSR states, with a bounded retry count and a guaranteed fallback.
- It returns the result over a valid/ready response channel.
- It sits directly downstream of the LFSR and feeds game/effect logic in the TinyTapeout design.

Parameters:
W, 8, width of range and result.
MAX_TRIES, 8, rejections allowed before the fallback path is taken (≥1).
STRIDE, 4, LFSR cycles between consecutive candidate samples (≥1), so candidates are decorrelated.

Ports:
clk_i  in  1  clock, rising edge.
reset_ni  in  1  asynchronous, active-low reset.
lfsr_state_i  in  32  current LFSR state; advances one step per cycle.
req_valid_i  in  1  request present.
req_ready_o  out  1  block can accept a request.
req_range_i  in  W  exclusive upper bound; sampled on the request handshake.
rsp_valid_o  out  1  result available.
rsp_ready_i  in  1  consumer accepts the result.
rsp_value_o  out  W  result, always < range when range ≠ 0.
rsp_fallback_o  out  1  result came from the fallback path.
rsp_error_o  out  1  range was 0.

Behaviour:
- Reset (async assert, sync deassert by design):
  - state IDLE, req_ready_o=1, rsp_valid_o=0.
  - rsp_value_o=0, rsp_fallback_o=0, rsp_error_o=0.
  - All counters 0.
  - Reset mid-operation discards the request; no response is issued.
- Mask: mask = (range−1) with all bits below its MSB set. For range=1, mask=0.
- Candidate: cand = lfsr_state_i[W-1:0] & mask.
- Fallback value: cand & (mask>>1). This is always < range when range ≥ 1, by construction.
- FSM states: IDLE, SAMPLE, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch range and mask, tries=0, stride_cnt=0.
  - If range==0: go to RESP with value 0, error=1, fallback=0.
  - Otherwise go to SAMPLE.
- SAMPLE:
  - req_ready_o=0.
  - When stride_cnt==0, evaluate cand:
    - cand < range: latch value, go to RESP, fallback=0.
    - Else if tries==MAX_TRIES−1: latch fallback value, go to RESP, fallback=1.
    - Else: tries++, stride_cnt=STRIDE−1, stay in SAMPLE.
  - When stride_cnt≠0: decrement it, no evaluation.
- RESP:
  - rsp_valid_o=1.
  - value, fallback and error are held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i: rsp_valid_o deasserts the next cycle and the FSM returns to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake (no overlap, no bypass).
- Latency: request handshake at edge n.
  - First evaluation uses lfsr_state_i in cycle n+1.
  - Accept on the first try: rsp_valid_o high from cycle n+2.
  - Worst case: rsp_valid_o from cycle n+2+(MAX_TRIES−1)·STRIDE.
  - range=0: rsp_valid_o at n+1.
- Power-of-two range: mask=range−1, so cand is never rejected.
- All outputs are registered. No combinational path from lfsr_state_i to any output.
- req_range_i changes after the handshake have no effect.

Decomposition:
- Shared package lfsr_pkg holds:
  - the sampler_state_e enum (IDLE, SAMPLE, RESP);
  - the default W/MAX_TRIES/STRIDE constants;
  - the LFSR width constant 32.
- One sub-module is natural: lfsr_mask_gen, a combinational MSB-smear from range−1 to mask, parameterised on W.

Test Plan:
- Accept first try: range=10, lfsr low byte 0x07 at the evaluation cycle → rsp_valid_o at handshake+2, value 7, fallback=0, error=0.
- Reject then accept: range=10, lfsr low bytes 0x0D then, STRIDE=4 cycles later, 0x03 → value 3 at handshake+6, fallback=0.
- Fallback: range=5, every evaluated low byte =0x07 (cand 7) → after 8 rejections, value 7&3=3, fallback=1, at handshake+2+7·4=+30.
- Range edges:
  - range=0 → value 0, error=1, rsp_valid_o at +1.
  - range=1 → value 0 at +2.
  - range=128, lfsr byte 0xFF → value 127.
- Backpressure: hold rsp_ready_i=0 for 10 cycles → value, flags and rsp_valid_o stable; req_ready_o=0 throughout; req_valid_i ignored until the cycle after the handshake.
- Reset mid-SAMPLE: pull reset_ni low asynchronously between clock edges → outputs go to reset values immediately; after release, req_ready_o=1 and no stale response appears.
